shift_right_seq: RTL and testbench
==================================

SHIFT_RIGHT_SEQ -- requirements
Module: shift_right_seq

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the datapath width in bits.
REQ-002 Parameter SHW, default 4, SHALL set the shift-amount width (clog2 of WIDTH).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request a shift; it is accepted only when ready=1.
REQ-006 data_in  input  WIDTH  SHALL be the operand, sampled on accept.
REQ-007 shamt  input  SHW  SHALL be the right-shift amount 0..WIDTH-1, sampled on accept.
REQ-008 arith  input  1  SHALL select arithmetic (1, MSB fill) or logical (0, zero fill), sampled on accept.
REQ-009 ready  output  1  SHALL be high only in IDLE.
REQ-010 done  output  1  SHALL pulse high for exactly one cycle when a result is valid.
REQ-011 data_out  output  WIDTH  SHALL carry the latest result and hold it until the next done.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE, with encodings from the shared package.
REQ-013 IDLE with start=1: capture data_in, shamt and arith into internal registers, load counter=shamt, then go to SHIFT if shamt!=0, else DONE.
REQ-014 IDLE with start=0 SHALL remain in IDLE.
REQ-015 Each SHIFT cycle SHALL shift the work register right by one bit, with fill = arith ? work[WIDTH-1] : 0, and decrement the counter.
REQ-016 SHIFT SHALL go to DONE on the cycle the counter transitions 1->0; the counter SHALL never wrap below 0.
REQ-017 DONE SHALL assert done, load data_out from the work register, and return to IDLE the next cycle.
REQ-018 Latency: with start accepted at edge T, done SHALL be high during cycle T+shamt+1, so the total is shamt+1 cycles and shamt=0 gives 1 cycle.
REQ-019 start while ready=0 SHALL be ignored without corrupting the operation in flight.
REQ-020 A new start SHALL be accepted in the cycle following done, so back-to-back operations need no idle gap beyond IDLE.
REQ-021 Input changes after accept SHALL NOT affect the result.
REQ-022 For arith=1, the result SHALL equal a signed two's-complement division by 2^shamt rounded toward minus infinity.

Reset
REQ-023 With rst_n=0, the block SHALL asynchronously force: state=IDLE, ready=1, done=0, data_out=0, counter=0, work register=0.
REQ-024 Reset asserted mid-SHIFT SHALL abort the operation, and no done SHALL follow.
REQ-025 After rst_n deassertion, the first start SHALL be accepted at the first rising edge.

Structure
REQ-026 A shared package SHALL hold the FSM state typedef/encodings and the default WIDTH/SHW constants.
REQ-027 One sub-module, rshift1_stage, SHALL perform the combinational single-bit right shift with the fill bit as an input.
REQ-028 The datapath SHALL register the work register and data_out, and SHALL NOT contain combinational paths from inputs to outputs.

Verification
REQ-029 data_in=0x8001, shamt=4, arith=0, start at T -> done at T+5, data_out=0x0800.
REQ-030 data_in=0x8001, shamt=4, arith=1 -> data_out=0xF800, done at T+5.
REQ-031 data_in=0x1234, shamt=0 -> done at T+1, data_out=0x1234; data_in=0x8000, shamt=15, arith=1 -> data_out=0xFFFF at T+16.
REQ-032 Second start with data_in=0xFFFF pulsed during SHIFT of 0x00F0 >> 4 logical -> ignored; data_out=0x000F, and exactly one done.
REQ-033 rst_n low at T+2 of a shamt=8 operation -> ready=1, done=0, data_out=0 immediately, and no done thereafter.
REQ-034 Back-to-back: 0x00FF>>1 then 0xFF00>>2 arith, with start re-asserted the cycle after the first done -> results 0x007F then 0xFFC0.

Source files
------------

// File: rtl/shift_right_seq_pkg.sv
// Shared definitions for the sequential right shifter: FSM state encoding
// and the default datapath/shift-amount widths.
package shift_right_seq_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_SHW   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_right_seq_if.sv
// Request/response bundle of the sequential right shifter; the master issues
// operands, the slave (the shifter) returns ready/done/result.
interface shift_right_seq_if #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shamt;
    logic             arith;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] data_out;

    modport master (
        output start, data_in, shamt, arith,
        input  ready, done, data_out
    );

    modport slave (
        input  start, data_in, shamt, arith,
        output ready, done, data_out
    );
endinterface

// File: rtl/shift_right_seq_rshift1_stage.sv
// Combinational one-bit right shift; the caller chooses the bit shifted in
// at the MSB, which is how logical and arithmetic shifts share this stage.
module rshift1_stage #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] din,
    input  logic             fill,
    output logic [WIDTH-1:0] dout
);

    assign dout = {fill, din[WIDTH-1:1]};

endmodule

// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter: one bit per clock, shamt cycles plus one DONE
// cycle, with all outputs registered.
module shift_right_seq
    import shift_right_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHW   = DEFAULT_SHW
) (
    input  logic            clk,
    input  logic            rst_n,
    shift_right_seq_if.slave bus
);

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_next;
    logic [SHW-1:0]   count;
    logic             arith_q;
    logic             ready_q;
    logic             done_q;
    logic [WIDTH-1:0] data_out_q;
    logic             fill;

    // Operand mode is latched at accept, so later changes on arith cannot
    // alter an operation already in flight.
    assign fill = arith_q & work[WIDTH-1];

    rshift1_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .din  (work),
        .fill (fill),
        .dout (work_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            work       <= '0;
            count      <= '0;
            arith_q    <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        work    <= bus.data_in;
                        count   <= bus.shamt;
                        arith_q <= bus.arith;
                        ready_q <= 1'b0;
                        state   <= (bus.shamt != '0) ? ST_SHIFT : ST_DONE;
                    end
                end
                ST_SHIFT: begin
                    work <= work_next;
                    if (count != '0) begin
                        count <= count - SHW'(1);
                    end
                    if (count == SHW'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q     <= 1'b1;
                    data_out_q <= work;
                    ready_q    <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Randomised scoreboard bench for shift_right_seq: the driver queues expected
// results from an arithmetic model, the monitor checks every done pulse.
module tb_shift_right_seq;
    import shift_right_seq_pkg::*;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    typedef struct {
        logic [WIDTH-1:0] result;
        int               shamt;
        int               accept_edge;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;
    logic prev_done;
    exp_t exp_q[$];

    shift_right_seq_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    shift_right_seq #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Floor division by 2^s for signed operands, plain division for unsigned.
    function automatic logic [WIDTH-1:0] model(logic [WIDTH-1:0] d, int s, bit a);
        int v;
        int p;
        int q;
        p = 1 << s;
        if (a) begin
            v = int'($signed(d));
            q = v / p;
            if ((v < 0) && (q * p != v)) q = q - 1;
        end else begin
            v = int'({16'h0, d});
            q = v / p;
        end
        return q[WIDTH-1:0];
    endfunction

    task automatic check_output(string name, logic [31:0] actual, logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    task automatic apply_stimulus(logic [WIDTH-1:0] d, int s, bit a);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        while (!bus.ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.ready) begin
            total++;
            bad++;
            $display("[TB] FAIL ready_timeout: got ready=0, expected ready=1 within 200 cycles");
            return;
        end
        bus.start   = 1'b1;
        bus.data_in = d;
        bus.shamt   = SHW'(s);
        bus.arith   = a;
        e.result      = model(d, s, a);
        e.shamt       = s;
        e.accept_edge = cyc + 1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.data_in = WIDTH'($urandom);
        bus.shamt   = SHW'($urandom);
        bus.arith   = 1'($urandom);
        exp_q.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done && prev_done) begin
                total++;
                bad++;
                $display("[TB] FAIL done_width: got done high for 2 cycles, expected 1");
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_done: got done=1 data_out=0x%0h, expected no done", bus.data_out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_output("data_out", 32'(bus.data_out), 32'(e.result));
                    check_output("latency", 32'(cyc - e.accept_edge), 32'(e.shamt + 1));
                end
            end
        end
        prev_done <= bus.done;
    end

    initial begin
        int waited;
        cyc       = 0;
        total     = 0;
        bad       = 0;
        prev_done = 1'b0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.data_in = '0;
        bus.shamt   = '0;
        bus.arith   = 1'b0;
        #12;
        check_output("reset_ready", 32'(bus.ready), 32'd1);
        check_output("reset_done", 32'(bus.done), 32'd0);
        check_output("reset_data_out", 32'(bus.data_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases, starting immediately after reset release.
        apply_stimulus(16'h8001, 4, 1'b0);
        apply_stimulus(16'h8001, 4, 1'b1);
        apply_stimulus(16'h1234, 0, 1'b0);
        apply_stimulus(16'h8000, 15, 1'b1);

        // A start pulsed while busy must be ignored.
        apply_stimulus(16'h00F0, 4, 1'b0);
        bus.start   = 1'b1;
        bus.data_in = 16'hFFFF;
        bus.shamt   = 4'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;

        // Back-to-back: second start waits only for ready.
        apply_stimulus(16'h00FF, 1, 1'b0);
        apply_stimulus(16'hFF00, 2, 1'b1);

        // Reset in the middle of a shift aborts it.
        apply_stimulus(16'hABCD, 8, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("abort_ready", 32'(bus.ready), 32'd1);
        check_output("abort_done", 32'(bus.done), 32'd0);
        check_output("abort_data_out", 32'(bus.data_out), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            apply_stimulus(WIDTH'($urandom), int'($urandom_range(0, WIDTH - 1)), 1'($urandom));
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        check_output("drain_pending", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
